// File: rtl/pwm_pkg.sv
`default_nettype none
// +------------------------------------------------------------------+
// | pwm_pkg : shared constants, counter direction type, width helper |
// | rev 1.0                                                          |
// +------------------------------------------------------------------+
package pwm_pkg;

  localparam logic PWM_EDGE   = 1'b0;
  localparam logic PWM_CENTER = 1'b1;

  localparam int DEFAULT_PERIOD_27M = 27000;

  typedef enum logic [0:0] {
    DIR_UP   = 1'b0,
    DIR_DOWN = 1'b1
  } dir_t;

  // Select-bus width that never collapses to zero for a single channel.
  function automatic int clog2_min1(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage
`default_nettype wire

// File: rtl/pwm_compare_ch.sv
`default_nettype none
// +------------------------------------------------------------------+
// | pwm_compare_ch : double-buffered duty and registered compare     |
// | rev 1.0                                                          |
// +------------------------------------------------------------------+
module pwm_compare_ch #(
  parameter int CNT_W = 15
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             i_bnd,
  input  logic             i_wr,
  input  logic [CNT_W-1:0] i_val,
  input  logic [CNT_W-1:0] i_cnt,
  input  logic             i_en,
  output logic             o_pwm,
  output logic             o_diff
);

  logic [CNT_W-1:0] r_shd;
  logic [CNT_W-1:0] r_act;
  logic [CNT_W-1:0] w_duty;
  logic             r_pwm;

  // The boundary cycle already belongs to the new period, so compare against
  // the duty being loaded rather than the one being retired.
  assign w_duty = i_bnd ? r_shd : r_act;
  assign o_diff = (r_shd != r_act);
  assign o_pwm  = r_pwm;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_shd <= '0;
      r_act <= '0;
      r_pwm <= 1'b0;
    end else begin
      if (i_wr)  r_shd <= i_val;
      if (i_bnd) r_act <= r_shd;
      r_pwm <= i_en && (i_cnt < w_duty);
    end
  end

endmodule
`default_nettype wire

// File: rtl/pwm_multi_ch.sv
`default_nettype none
// +------------------------------------------------------------------+
// | pwm_multi_ch : shared-counter multi-channel PWM, edge or center  |
// | rev 1.0                                                          |
// +------------------------------------------------------------------+
module pwm_multi_ch
  import pwm_pkg::*;
#(
  parameter int CHANNELS       = 4,
  parameter int CNT_W          = 15,
  parameter int DEFAULT_PERIOD = DEFAULT_PERIOD_27M
) (
  input  logic                              clk,
  input  logic                              rst,
  input  logic                              period_wr,
  input  logic [CNT_W-1:0]                  period_val,
  input  logic                              mode_wr,
  input  logic                              mode_val,
  input  logic                              duty_wr,
  input  logic [clog2_min1(CHANNELS)-1:0]   duty_ch,
  input  logic [CNT_W-1:0]                  duty_val,
  input  logic [CHANNELS-1:0]               ch_en,
  output logic [CHANNELS-1:0]               pwm_out,
  output logic                              period_start,
  output logic                              update_pending
);

  localparam logic [CNT_W-1:0] c_DEF_PERIOD = CNT_W'(DEFAULT_PERIOD);
  localparam logic [CNT_W-1:0] c_MIN_PERIOD = CNT_W'(2);
  localparam logic [CNT_W-1:0] c_ONE        = CNT_W'(1);

  logic [CNT_W-1:0]    r_cnt;
  dir_t                r_dir;
  logic [CNT_W-1:0]    r_act_period;
  logic [CNT_W-1:0]    r_shd_period;
  logic                r_act_mode;
  logic                r_shd_mode;
  logic                r_period_start;

  logic [CNT_W-1:0]    w_cnt_nxt;
  dir_t                w_dir_nxt;
  logic [CNT_W-1:0]    w_top;
  logic                w_bnd;
  logic [CHANNELS-1:0] w_diff;

  assign w_bnd = (r_cnt == '0) && (r_dir == DIR_UP);
  assign w_top = ((r_act_period < c_MIN_PERIOD) ? c_MIN_PERIOD : r_act_period) - c_ONE;

  // With P = 2 the down leg is empty, so center mode folds straight back to 0.
  always_comb begin
    w_cnt_nxt = r_cnt + c_ONE;
    w_dir_nxt = r_dir;
    case (r_dir)
      DIR_UP: begin
        if (r_cnt >= w_top) begin
          if ((r_act_mode == PWM_CENTER) && (w_top > c_ONE)) begin
            w_cnt_nxt = w_top - c_ONE;
            w_dir_nxt = DIR_DOWN;
          end else begin
            w_cnt_nxt = '0;
            w_dir_nxt = DIR_UP;
          end
        end
      end
      DIR_DOWN: begin
        w_cnt_nxt = r_cnt - c_ONE;
        if (r_cnt <= c_ONE) begin
          w_cnt_nxt = '0;
          w_dir_nxt = DIR_UP;
        end
      end
      default: begin
        w_cnt_nxt = '0;
        w_dir_nxt = DIR_UP;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_cnt          <= '0;
      r_dir          <= DIR_UP;
      r_act_period   <= c_DEF_PERIOD;
      r_shd_period   <= c_DEF_PERIOD;
      r_act_mode     <= PWM_EDGE;
      r_shd_mode     <= PWM_EDGE;
      r_period_start <= 1'b0;
    end else begin
      r_cnt          <= w_cnt_nxt;
      r_dir          <= w_dir_nxt;
      r_period_start <= w_bnd;
      if (period_wr) r_shd_period <= period_val;
      if (mode_wr)   r_shd_mode   <= mode_val;
      if (w_bnd) begin
        r_act_period <= r_shd_period;
        r_act_mode   <= r_shd_mode;
      end
    end
  end

  for (genvar gi = 0; gi < CHANNELS; gi++) begin : g_ch
    pwm_compare_ch #(
      .CNT_W (CNT_W)
    ) u_ch (
      .clk    (clk),
      .rst    (rst),
      .i_bnd  (w_bnd),
      .i_wr   (duty_wr && (int'(duty_ch) == gi)),
      .i_val  (duty_val),
      .i_cnt  (r_cnt),
      .i_en   (ch_en[gi]),
      .o_pwm  (pwm_out[gi]),
      .o_diff (w_diff[gi])
    );
  end

  assign period_start   = r_period_start;
  assign update_pending = (r_shd_period != r_act_period) || (r_shd_mode != r_act_mode) || (|w_diff);

endmodule
`default_nettype wire

// File: tb/tb_pwm_multi_ch.sv
`default_nettype none
// +------------------------------------------------------------------+
// | tb_pwm_multi_ch : directed stimulus, phase-based reference model |
// | rev 1.0                                                          |
// +------------------------------------------------------------------+
module tb_pwm_multi_ch;

  localparam int NCH = 4;
  localparam int W   = 15;

  logic           clk        = 1'b0;
  logic           rst        = 1'b1;
  logic           period_wr  = 1'b0;
  logic [W-1:0]   period_val = '0;
  logic           mode_wr    = 1'b0;
  logic           mode_val   = 1'b0;
  logic           duty_wr    = 1'b0;
  logic [1:0]     duty_ch    = '0;
  logic [W-1:0]   duty_val   = '0;
  logic [NCH-1:0] ch_en      = '1;
  logic [NCH-1:0] pwm_out;
  logic           period_start;
  logic           update_pending;

  int n_tests = 0;
  int n_fail  = 0;
  int hi[NCH];

  always #5 clk = ~clk;

  pwm_multi_ch #(
    .CHANNELS       (NCH),
    .CNT_W          (W),
    .DEFAULT_PERIOD (27000)
  ) dut (
    .clk            (clk),
    .rst            (rst),
    .period_wr      (period_wr),
    .period_val     (period_val),
    .mode_wr        (mode_wr),
    .mode_val       (mode_val),
    .duty_wr        (duty_wr),
    .duty_ch        (duty_ch),
    .duty_val       (duty_val),
    .ch_en          (ch_en),
    .pwm_out        (pwm_out),
    .period_start   (period_start),
    .update_pending (update_pending)
  );

  // Reference: position within the period, folded into a counter value for center mode.
  int m_phase = 0, m_p = 27000, m_mode = 0, m_sp = 27000, m_sm = 0;
  int m_d[NCH], m_sd[NCH];
  int m_pe, m_len, m_cnt;
  logic [NCH-1:0] e_pwm  = '0;
  logic           e_ps   = 1'b0;
  logic           e_pend = 1'b0;

  always @(posedge clk) begin
    if (rst) begin
      m_phase = 0; m_p = 27000; m_sp = 27000; m_mode = 0; m_sm = 0;
      for (int i = 0; i < NCH; i++) begin m_d[i] = 0; m_sd[i] = 0; end
      e_pwm = '0;
      e_ps  = 1'b0;
    end else begin
      if (m_phase == 0) begin
        m_p = m_sp; m_mode = m_sm;
        for (int i = 0; i < NCH; i++) m_d[i] = m_sd[i];
      end
      m_pe  = (m_p < 2) ? 2 : m_p;
      m_len = (m_mode != 0) ? 2 * (m_pe - 1) : m_pe;
      m_cnt = (m_phase < m_pe) ? m_phase : 2 * m_pe - 2 - m_phase;
      for (int i = 0; i < NCH; i++) e_pwm[i] = ch_en[i] && (m_cnt < m_d[i]);
      e_ps = (m_phase == 0);
      if (period_wr) m_sp = int'(period_val);
      if (mode_wr)   m_sm = int'(mode_val);
      if (duty_wr)   m_sd[duty_ch] = int'(duty_val);
      m_phase = (m_phase + 1) % m_len;
    end
    e_pend = (m_sp != m_p) || (m_sm != m_mode);
    for (int i = 0; i < NCH; i++) if (m_sd[i] != m_d[i]) e_pend = 1'b1;
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  always @(posedge clk) begin
    #1;
    check("model_pwm_out", 32'(pwm_out), 32'(e_pwm));
    check("model_period_start", 32'(period_start), 32'(e_ps));
    check("model_update_pending", 32'(update_pending), 32'(e_pend));
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wr(input logic pw, input int pv, input logic mw, input logic mv,
                    input logic dw, input int dc, input int dv);
    @(negedge clk);
    period_wr = pw; period_val = W'(pv);
    mode_wr   = mw; mode_val   = mv;
    duty_wr   = dw; duty_ch    = 2'(dc); duty_val = W'(dv);
    tick();
    period_wr = 1'b0; mode_wr = 1'b0; duty_wr = 1'b0;
  endtask

  task automatic wait_ps(output int n);
    n = 0;
    do begin
      tick();
      n++;
    end while (!period_start && n < 40000);
    if (!period_start) check("period_start_timeout", 32'(0), 32'(1));
  endtask

  task automatic count_hi(input int n);
    for (int c = 0; c < NCH; c++) hi[c] = 0;
    repeat (n) begin
      for (int c = 0; c < NCH; c++) hi[c] += int'(pwm_out[c]);
      tick();
    end
  endtask

  initial begin
    int n;
    repeat (3) tick();
    check("rst_pwm", 32'(pwm_out), 0);
    check("rst_period_start", 32'(period_start), 0);
    check("rst_pending", 32'(update_pending), 0);
    @(negedge clk);
    rst = 1'b0;
    tick();
    check("first_period_start", 32'(period_start), 1);
    wait_ps(n);
    check("default_period_len", 32'(n), 27000);

    // Edge mode, P = 10, duties 3 / 0 / 10 / 15
    wr(1'b1, 10, 1'b0, 1'b0, 1'b1, 0, 3);
    wr(1'b0, 0, 1'b0, 1'b0, 1'b1, 1, 0);
    wr(1'b0, 0, 1'b0, 1'b0, 1'b1, 2, 10);
    wr(1'b0, 0, 1'b0, 1'b0, 1'b1, 3, 15);
    check("pending_after_writes", 32'(update_pending), 1);
    wait_ps(n);
    check("wait_default_tail", 32'(n), 26996);
    check("pending_cleared", 32'(update_pending), 0);
    count_hi(10);
    check("edge_hi_ch0", 32'(hi[0]), 3);
    check("edge_hi_ch1", 32'(hi[1]), 0);
    check("edge_hi_ch2", 32'(hi[2]), 10);
    check("edge_hi_ch3", 32'(hi[3]), 10);
    check("edge_next_start", 32'(period_start), 1);

    // Center mode, ch0 duty 4
    wr(1'b0, 0, 1'b1, 1'b1, 1'b1, 0, 4);
    wait_ps(n);
    check("edge_tail_len", 32'(n), 9);
    count_hi(18);
    check("center_hi_ch0", 32'(hi[0]), 7);
    check("center_hi_ch2", 32'(hi[2]), 18);
    check("center_len", 32'(period_start), 1);

    // Back to edge, duty 2 then 8 written mid-period
    wr(1'b0, 0, 1'b1, 1'b0, 1'b1, 0, 2);
    wait_ps(n);
    check("center_tail_len", 32'(n), 17);
    count_hi(10);
    check("duty2_hi_ch0", 32'(hi[0]), 2);
    repeat (3) tick();
    wr(1'b0, 0, 1'b0, 1'b0, 1'b1, 0, 8);
    check("midwrite_pending", 32'(update_pending), 1);
    wait_ps(n);
    check("midwrite_tail", 32'(n), 6);
    check("midwrite_pending_clr", 32'(update_pending), 0);
    count_hi(10);
    check("duty8_hi_ch0", 32'(hi[0]), 8);

    // Writes landing on the boundary cycle itself: period 1 (clamped to 2), duty 1
    repeat (9) tick();
    wr(1'b1, 1, 1'b0, 1'b0, 1'b1, 0, 1);
    check("bnd_write_start", 32'(period_start), 1);
    check("bnd_write_pending", 32'(update_pending), 1);
    count_hi(10);
    check("bnd_old_duty_hi", 32'(hi[0]), 8);
    check("bnd_applied_start", 32'(period_start), 1);
    check("bnd_applied_pending", 32'(update_pending), 0);
    count_hi(2);
    check("p2_hi_ch0", 32'(hi[0]), 1);
    check("p2_hi_ch2", 32'(hi[2]), 2);
    wait_ps(n);
    check("p2_len", 32'(n), 2);

    // Channel enable acts without waiting for a boundary
    @(negedge clk); ch_en[2] = 1'b0;
    tick();
    check("en_off_ch2", 32'(pwm_out[2]), 0);
    @(negedge clk); ch_en[2] = 1'b1;
    tick();
    check("en_on_ch2", 32'(pwm_out[2]), 1);

    // Reset mid-period with a write pending
    wr(1'b0, 0, 1'b0, 1'b0, 1'b1, 1, 7);
    check("pre_rst_pending", 32'(update_pending), 1);
    @(negedge clk); rst = 1'b1;
    tick();
    check("midrst_pwm", 32'(pwm_out), 0);
    check("midrst_period_start", 32'(period_start), 0);
    check("midrst_pending", 32'(update_pending), 0);
    @(negedge clk); rst = 1'b0;
    tick();
    check("post_rst_start", 32'(period_start), 1);
    repeat (20) tick();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #1500000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1, "watchdog");
  end

endmodule
`default_nettype wire
